// File: rtl/ofdm_stream_pkg.sv
// Shared constants and width helpers for the OFDM bit-stream P2S/S2P stages.
package ofdm_stream_pkg;
    localparam int DEF_WIDTH = 2;
    localparam int DEF_DEPTH = 256;

    typedef enum logic {
        P2S_IDLE  = 1'b0,
        P2S_SHIFT = 1'b1
    } p2s_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Occupancy counters must be able to hold the value DEPTH itself.
    function automatic int occ_w(input int depth);
        return clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/p2s_sync_fifo.sv
// Synchronous WIDTH x DEPTH FIFO; head word visible on rdata whenever !empty.
// full/count/avail are registered; empty is derived from the registered count.
module p2s_sync_fifo
    import ofdm_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = occ_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [AW-1:0]    count,
    output logic [AW-1:0]    avail
);
    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    count_q, count_d;
    logic [AW-1:0]    avail_q, avail_d;
    logic             full_q, full_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + AW'(push) - AW'(pop);
        avail_d = AW'(DEPTH) - count_d;
        full_d  = (count_d == AW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            avail_q  <= AW'(DEPTH);
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            avail_q  <= avail_d;
            full_q   <= full_d;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = full_q;
    assign count = count_q;
    assign avail = avail_q;
endmodule

// File: rtl/encoder_out_p2s.sv
// Parallel-to-serial TX stage: FIFO-buffered words shifted out one bit per handshake.
// Bit order is LSB first by default; define P2S_MSB_FIRST_EN for MSB first.
module encoder_out_p2s
    import ofdm_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = occ_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_Par,
    input  logic             din_vld,
    output logic             dout_rdy,
    output logic             dout_Ser,
    output logic             dout_vld,
    input  logic             din_rdy,
    output logic [AW-1:0]    occupancy,
    output logic [AW-1:0]    availability
);
    localparam int            BW   = clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    logic             push, pop, fifo_empty, fifo_full;
    logic [WIDTH-1:0] fifo_rdata;

    p2s_state_e       st_q, st_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             dout_ser_q, dout_ser_d;
    logic             dout_vld_q, dout_vld_d;
    logic [BW-1:0]    idx;

    // Ready is the registered !full, so a pop in the full cycle cannot admit a push.
    assign push = din_vld && !fifo_full;

    p2s_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (din_Par),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (occupancy),
        .avail (availability)
    );

    always_comb begin
        st_d   = st_q;
        sreg_d = sreg_q;
        bcnt_d = bcnt_q;
        pop    = 1'b0;
        case (st_q)
            P2S_IDLE: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    sreg_d = fifo_rdata;
                    bcnt_d = '0;
                    st_d   = P2S_SHIFT;
                end
            end
            default: begin
                if (din_rdy) begin
                    if (bcnt_q != LAST) begin
                        bcnt_d = bcnt_q + BW'(1);
                    end else if (!fifo_empty) begin
                        // Reload on the last bit so the stream has no bubble.
                        pop    = 1'b1;
                        sreg_d = fifo_rdata;
                        bcnt_d = '0;
                    end else begin
                        st_d = P2S_IDLE;
                    end
                end
            end
        endcase
`ifdef P2S_MSB_FIRST_EN
        idx = LAST - bcnt_d;
`else
        idx = bcnt_d;
`endif
        dout_vld_d = (st_d == P2S_SHIFT);
        dout_ser_d = dout_vld_d ? sreg_d[idx] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= P2S_IDLE;
            sreg_q     <= '0;
            bcnt_q     <= '0;
            dout_ser_q <= 1'b0;
            dout_vld_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            sreg_q     <= sreg_d;
            bcnt_q     <= bcnt_d;
            dout_ser_q <= dout_ser_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign dout_rdy = !fifo_full;
    assign dout_Ser = dout_ser_q;
    assign dout_vld = dout_vld_q;
endmodule

// File: tb/tb_encoder_out_p2s.sv
// Self-checking bench for encoder_out_p2s: vector table, streaming, backpressure, stall, reset.
module tb_encoder_out_p2s;
    localparam int WIDTH = 2;
    localparam int DEPTH = 256;
    localparam int AW    = 9;

    logic             clk, rst_n;
    logic [WIDTH-1:0] din_Par;
    logic             din_vld, din_rdy;
    logic             dout_rdy, dout_Ser, dout_vld;
    logic [AW-1:0]    occupancy, availability;

    encoder_out_p2s #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_Par      (din_Par),
        .din_vld      (din_vld),
        .dout_rdy     (dout_rdy),
        .dout_Ser     (dout_Ser),
        .dout_vld     (dout_vld),
        .din_rdy      (din_rdy),
        .occupancy    (occupancy),
        .availability (availability)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] w;
        logic             b0;
        logic             b1;
    } vec_t;

    vec_t tbl[4];
    logic q[$];
    int   checks, failures;
    int   acc;
    logic prev_stall, prev_ser;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard sample, mid-cycle: inputs and outputs are stable for the coming edge.
    task automatic sb_sample();
        logic e;
        if (prev_stall) begin
            chk("stall_vld", 32'(dout_vld), 1);
            chk("stall_ser", 32'(dout_Ser), 32'(prev_ser));
        end
        prev_stall = dout_vld && !din_rdy;
        prev_ser   = dout_Ser;
        if (din_vld && dout_rdy) begin
            acc++;
            for (int i = 0; i < WIDTH; i++) begin
`ifdef P2S_MSB_FIRST_EN
                q.push_back(din_Par[WIDTH-1-i]);
`else
                q.push_back(din_Par[i]);
`endif
            end
        end
        if (dout_vld && din_rdy) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sb_bit", 32'(dout_Ser), 32'(e));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input vec_t v);
        din_vld = 1'b1; din_Par = v.w; din_rdy = 1'b1;
        tick();
        din_vld = 1'b0;
        chk("lat_vld0", 32'(dout_vld), 0);
        tick();
        chk("bit0_vld", 32'(dout_vld), 1);
        chk("bit0_ser", 32'(dout_Ser), 32'(v.b0));
        tick();
        chk("bit1_vld", 32'(dout_vld), 1);
        chk("bit1_ser", 32'(dout_Ser), 32'(v.b1));
        tick();
        chk("after_vld", 32'(dout_vld), 0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        din_vld = 1'b0; din_rdy = 1'b1;
        while ((q.size() != 0 || dout_vld) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_left", q.size(), 0);
        chk("drain_vld", 32'(dout_vld), 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_vld", 32'(dout_vld), 0);
        chk("rst_ser", 32'(dout_Ser), 0);
        chk("rst_rdy", 32'(dout_rdy), 1);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_avail", 32'(availability), DEPTH);
    endtask

    initial begin
        int bubbles, max_occ;
        checks = 0; failures = 0; acc = 0;
        prev_stall = 1'b0; prev_ser = 1'b0;
        rst_n = 1'b0; din_vld = 1'b0; din_Par = '0; din_rdy = 1'b0;

`ifdef P2S_MSB_FIRST_EN
        tbl[0] = '{2'b00, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 1'b0, 1'b1};
        tbl[2] = '{2'b10, 1'b1, 1'b0};
        tbl[3] = '{2'b11, 1'b1, 1'b1};
`else
        tbl[0] = '{2'b00, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 1'b1, 1'b0};
        tbl[2] = '{2'b10, 1'b0, 1'b1};
        tbl[3] = '{2'b11, 1'b1, 1'b1};
`endif

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst_n = 1'b1;
        tick();

        // Single-word vectors, spec case 2'b10 first.
        single(tbl[2]);
        for (int i = 0; i < 4; i++) single(tbl[i]);

        // Streaming: one word per WIDTH cycles keeps the serializer saturated.
        bubbles = 0; max_occ = 0;
        din_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            din_vld = (i % 2 == 0);
            din_Par = WIDTH'($urandom);
            tick();
            if (i >= 1 && !dout_vld) bubbles++;
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
        din_vld = 1'b0;
        chk("stream_bubbles", bubbles, 0);
        chk("stream_occ_le1", (max_occ <= 1) ? 1 : 0, 1);
        drain(50);

        // Backpressure until full.
        acc = 0;
        din_rdy = 1'b0;
        for (int i = 0; i < 258; i++) begin
            din_vld = 1'b1;
            din_Par = WIDTH'($urandom);
            tick();
        end
        din_vld = 1'b0;
        tick();
        chk("full_accepted", acc, 257);
        chk("full_occ", 32'(occupancy), DEPTH);
        chk("full_avail", 32'(availability), 0);
        chk("full_rdy", 32'(dout_rdy), 0);
        chk("full_vld", 32'(dout_vld), 1);
        din_rdy = 1'b1;
        tick();
        tick();
        chk("rdy_after_pop", 32'(dout_rdy), 1);
        drain(2000);
        chk("empty_occ", 32'(occupancy), 0);
        chk("empty_avail", 32'(availability), DEPTH);

        // Random stalls on both sides.
        for (int i = 0; i < 400; i++) begin
            din_vld = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
            din_Par = WIDTH'($urandom);
            din_rdy = 1'($urandom_range(0, 1));
            tick();
        end
        drain(1000);

        // Asynchronous reset mid-word.
        din_rdy = 1'b0; din_vld = 1'b1; din_Par = 2'b11;
        tick();
        din_vld = 1'b0;
        tick();
        tick();
        chk("pre_rst_vld", 32'(dout_vld), 1);
        chk("pre_rst_ser", 32'(dout_Ser), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_vld", 32'(dout_vld), 0);
        single(tbl[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
